batcharger_controller_gen2: RTL and testbench
=============================================

// Module: batcharger_controller_gen2
// PURPOSE
//  Second-generation Li-ion charge controller FSM: TC -> CC -> CV -> DONE, sequencing the analog
//  charger (cc/tc/cv) and ADC monitor enables. Over gen1 it adds parametrised ADC width and timer base,
//  temperature pause/resume with held timer, debounced end-of-charge, recharge hysteresis,
//  overvoltage/timeout FAULT state with fault code. Sits between OTP/ADC block and analog charger core.
// PARAMETERS
//  W      8   ADC / OTP threshold width (bits)
//  TDIV   8   prescaler bits; one timer tick = 2^TDIV clk cycles
//  TW     8   tmax width; charge timer counts ticks, TW bits
//  DEB    4   consecutive cycles ibat<iend required to end CV (>=1)
//  RECHG  8   recharge hysteresis below vpreset, ADC LSBs
// PORTS
//  clk      in   1   state machine clock
//  rstz     in   1   async active-low system reset
//  en       in   1   module enable; low -> IDLE (sync)
//  vtok     in   1   ADC voltage/temperature values valid
//  vbat     in   W   battery voltage code
//  ibat     in   W   battery current code
//  tbat     in   W   battery temperature code
//  vcutoff  in   W   OTP: TC exit threshold
//  vpreset  in   W   OTP: CC->CV threshold
//  vmax     in   W   OTP: overvoltage threshold (must be > vpreset)
//  tempmin  in   W   OTP: min temperature (exclusive)
//  tempmax  in   W   OTP: max temperature (exclusive)
//  tmax     in   TW  OTP: max charge time in ticks (0 = immediate timeout)
//  iend     in   W   OTP: end-of-charge current
//  cc,tc,cv out  1   analog mode selects, one-hot or all zero
//  imonen, vmonen, tmonen out 1  monitor enables
//  state    out  3   current state code (debug/status)
//  fault    out  2   0 none, 1 timeout, 2 overvoltage; sticky until IDLE
//  done     out  1   high in DONE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timers/debounce 0. All outputs registered, same edge as state.
//  en=0 or vtok=0 (sampled) -> IDLE next edge, timers cleared, fault cleared; overrides all below.
//  Comparisons unsigned; "in window" = tempmin<tbat<tempmax (strict).
//  IDLE  : -> WAIT when en&vtok.
//  WAIT  : vbat>vmax -> DONE; else in window -> resume phase (TC on first entry); else stay.
//  TC    : tc=1. vbat>vcutoff -> CC.
//  CC    : cc=1. vbat>vpreset -> CV.
//  CV    : cv=1. debounce cnt incr while ibat<iend, else 0; cnt==DEB -> DONE.
//  TC/CC/CV common, priority order: vbat>vmax -> FAULT(2); timer==tmax -> CV:DONE, TC/CC:FAULT(1);
//   out of window -> WAIT, resume phase stored, timer and prescaler held (not cleared).
//  DONE  : vbat<vcutoff -> TC; else vbat<sat0(vpreset-RECHG) -> CC; timer cleared on either exit.
//  FAULT : all modes 0; exits only via en/vtok low or rstz.
//  Timer: prescaler free-runs only in TC/CC/CV; tick on wrap; timer saturates at 2^TW-1.
//  Monitors: vmonen=tmonen=1 in every state except IDLE; imonen=1 in CC/CV/DONE.
//  Simultaneous: phase advance and timeout same cycle -> timeout wins; vmax check beats all.
// STRUCTURE
//  Package batcharger_pkg: state encodings (IDLE..FAULT), fault codes, mode one-hot constants.
//  Sub-module batcharger_timer: prescaler + TW-bit charge timer, inputs run/clear, output expired.
// TESTING
//  Full cycle W=8: vbat 100->150->190, vcutoff=147,vpreset=188 -> TC,CC,CV; ibat<iend 4 cyc -> DONE.
//  Temp pause: tbat leaves window in CC for 50 cyc -> WAIT, timer frozen; returns -> CC, timer resumes.
//  Timeout: TDIV=2,tmax=3 held in TC -> FAULT, fault=1 after 12 active cycles; en low -> IDLE, fault=0.
//  Overvoltage: vbat=220>vmax=214 in CV -> FAULT, fault=2, cc/tc/cv=0 next edge.
//  Recharge: DONE, vbat drops to 179 (vpreset 188,RECHG 8) -> CC; to 140 -> TC.
//  rstz low mid-CV, async -> all outputs 0 immediately; ibat glitch <DEB cycles does not end CV.

Source files
------------

// File: rtl/batcharger_pkg.sv
// Shared encodings for the gen2 Li-ion charge controller: FSM states, fault codes, analog mode selects.
package batcharger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_TC    = 3'd2,
    ST_CC    = 3'd3,
    ST_CV    = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_TIMEOUT = 2'd1,
    FLT_OVERV   = 2'd2
  } fault_e;

  // Mode vector bit order is {cv, cc, tc}
  localparam logic [2:0] MODE_OFF = 3'b000;
  localparam logic [2:0] MODE_TC  = 3'b001;
  localparam logic [2:0] MODE_CC  = 3'b010;
  localparam logic [2:0] MODE_CV  = 3'b100;

  function automatic logic [2:0] mode_of(input state_e s);
    case (s)
      ST_TC:   mode_of = MODE_TC;
      ST_CC:   mode_of = MODE_CC;
      ST_CV:   mode_of = MODE_CV;
      default: mode_of = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/batcharger_timer.sv
// Charge timer: 2^TDIV-cycle prescaler feeding a saturating TW-bit tick counter, held when not running.
module batcharger_timer #(
  parameter int unsigned TDIV = 8,
  parameter int unsigned TW   = 8
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          run,
  input  logic          clear,
  input  logic [TW-1:0] tmax,
  output logic          expired
);

  logic [TDIV-1:0] r_pre;
  logic [TW-1:0]   r_timer;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_pre   <= '0;
      r_timer <= '0;
    end else if (clear) begin
      r_pre   <= '0;
      r_timer <= '0;
    end else if (run) begin
      r_pre <= r_pre + TDIV'(1);
      if ((&r_pre) && !(&r_timer)) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  assign expired = (r_timer == tmax);

endmodule

// File: rtl/batcharger_controller_gen2.sv
// Gen2 Li-ion charge controller: TC -> CC -> CV -> DONE sequencing with temperature pause,
// debounced end-of-charge, recharge hysteresis and sticky timeout/overvoltage fault.
module batcharger_controller_gen2
  import batcharger_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned TDIV  = 8,
  parameter int unsigned TW    = 8,
  parameter int unsigned DEB   = 4,
  parameter int unsigned RECHG = 8
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          en,
  input  logic          vtok,
  input  logic [W-1:0]  vbat,
  input  logic [W-1:0]  ibat,
  input  logic [W-1:0]  tbat,
  input  logic [W-1:0]  vcutoff,
  input  logic [W-1:0]  vpreset,
  input  logic [W-1:0]  vmax,
  input  logic [W-1:0]  tempmin,
  input  logic [W-1:0]  tempmax,
  input  logic [TW-1:0] tmax,
  input  logic [W-1:0]  iend,
  output logic          cc,
  output logic          tc,
  output logic          cv,
  output logic          imonen,
  output logic          vmonen,
  output logic          tmonen,
  output logic [2:0]    state,
  output logic [1:0]    fault,
  output logic          done
);

  localparam int unsigned DW      = $clog2(DEB + 1);
  localparam logic [W-1:0] RECHG_W = W'(RECHG);

  state_e        r_state, r_resume;
  fault_e        r_fault;
  logic [DW-1:0] r_deb;

  state_e        w_nxt, w_nxt_resume;
  fault_e        w_nxt_fault;
  logic [DW-1:0] w_deb_nxt;
  logic [W-1:0]  w_rechg_thr;
  logic          w_in_win, w_ovp, w_expired, w_run, w_clear;

  assign w_in_win    = (tbat > tempmin) && (tbat < tempmax);
  assign w_ovp       = (vbat > vmax);
  assign w_deb_nxt   = (ibat < iend) ? r_deb + DW'(1) : '0;
  assign w_rechg_thr = (vpreset > RECHG_W) ? vpreset - RECHG_W : '0;
  assign w_run       = (r_state == ST_TC) || (r_state == ST_CC) || (r_state == ST_CV);
  // Clearing throughout DONE is equivalent to clearing on its exit, as nothing runs the timer there
  assign w_clear     = (r_state == ST_IDLE) || (r_state == ST_DONE);

  batcharger_timer #(
    .TDIV(TDIV),
    .TW  (TW)
  ) u_timer (
    .clk    (clk),
    .rstz   (rstz),
    .run    (w_run),
    .clear  (w_clear),
    .tmax   (tmax),
    .expired(w_expired)
  );

  always_comb begin
    w_nxt        = r_state;
    w_nxt_fault  = r_fault;
    w_nxt_resume = r_resume;
    if (!en || !vtok) begin
      w_nxt        = ST_IDLE;
      w_nxt_fault  = FLT_NONE;
      w_nxt_resume = ST_TC;
    end else begin
      case (r_state)
        ST_IDLE: w_nxt = ST_WAIT;
        ST_WAIT: begin
          if (w_ovp)         w_nxt = ST_DONE;
          else if (w_in_win) w_nxt = r_resume;
        end
        ST_TC, ST_CC, ST_CV: begin
          if (w_ovp) begin
            w_nxt       = ST_FAULT;
            w_nxt_fault = FLT_OVERV;
          end else if (w_expired) begin
            if (r_state == ST_CV) begin
              w_nxt = ST_DONE;
            end else begin
              w_nxt       = ST_FAULT;
              w_nxt_fault = FLT_TIMEOUT;
            end
          end else if (!w_in_win) begin
            w_nxt        = ST_WAIT;
            w_nxt_resume = r_state;
          end else begin
            case (r_state)
              ST_TC:   if (vbat > vcutoff)     w_nxt = ST_CC;
              ST_CC:   if (vbat > vpreset)     w_nxt = ST_CV;
              default: if (w_deb_nxt == DW'(DEB)) w_nxt = ST_DONE;
            endcase
          end
        end
        ST_DONE: begin
          if (vbat < vcutoff)          w_nxt = ST_TC;
          else if (vbat < w_rechg_thr) w_nxt = ST_CC;
        end
        ST_FAULT: w_nxt = ST_FAULT;
        default:  w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state      <= ST_IDLE;
      r_resume     <= ST_TC;
      r_fault      <= FLT_NONE;
      r_deb        <= '0;
      {cv, cc, tc} <= MODE_OFF;
      done         <= 1'b0;
      imonen       <= 1'b0;
      vmonen       <= 1'b0;
      tmonen       <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_resume     <= w_nxt_resume;
      r_fault      <= w_nxt_fault;
      r_deb        <= (r_state == ST_CV) ? w_deb_nxt : '0;
      {cv, cc, tc} <= mode_of(w_nxt);
      done         <= (w_nxt == ST_DONE);
      imonen       <= (w_nxt == ST_CC) || (w_nxt == ST_CV) || (w_nxt == ST_DONE);
      vmonen       <= (w_nxt != ST_IDLE);
      tmonen       <= (w_nxt != ST_IDLE);
    end
  end

  assign state = r_state;
  assign fault = r_fault;

endmodule

// File: tb/tb_batcharger_controller_gen2.sv
// Bench for batcharger_controller_gen2: cycle-level reference model plus directed scenarios.
module tb_batcharger_controller_gen2;

  localparam int W = 8, TDIV = 2, TW = 8, DEB = 4, RECHG = 8;
  localparam int TMR_MAX = (1 << TW) - 1;
  localparam int S_IDLE = 0, S_WAIT = 1, S_TC = 2, S_CC = 3, S_CV = 4, S_DONE = 5, S_FAULT = 6;

  logic clk = 1'b0, rstz = 1'b0, en = 1'b0, vtok = 1'b0;
  logic [W-1:0] vbat = 8'd100, ibat = 8'd100, tbat = 8'd50;
  logic [W-1:0] vcutoff = 8'd147, vpreset = 8'd188, vmax = 8'd214;
  logic [W-1:0] tempmin = 8'd10, tempmax = 8'd100, iend = 8'd20;
  logic [TW-1:0] tmax = 8'd200;
  logic cc, tc, cv, imonen, vmonen, tmonen, done;
  logic [2:0] state;
  logic [1:0] fault;

  int n_checks = 0, n_fail = 0;

  batcharger_controller_gen2 #(
    .W(W), .TDIV(TDIV), .TW(TW), .DEB(DEB), .RECHG(RECHG)
  ) dut (
    .clk(clk), .rstz(rstz), .en(en), .vtok(vtok),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vcutoff(vcutoff), .vpreset(vpreset), .vmax(vmax),
    .tempmin(tempmin), .tempmax(tempmax), .tmax(tmax), .iend(iend),
    .cc(cc), .tc(tc), .cv(cv), .imonen(imonen), .vmonen(vmonen), .tmonen(tmonen),
    .state(state), .fault(fault), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: charge time is tracked as total active cycles, ticks derived by division
  int m_st = S_IDLE, m_fault = 0, m_active = 0, m_deb = 0, m_resume = S_TC;

  always @(posedge clk or negedge rstz) begin : model
    int st, act, deb, flt, res, tmr, rthr;
    bit inwin;
    if (!rstz) begin
      m_st <= S_IDLE; m_fault <= 0; m_active <= 0; m_deb <= 0; m_resume <= S_TC;
    end else begin
      st = m_st; act = m_active; flt = m_fault; res = m_resume;
      tmr = m_active / (1 << TDIV);
      if (tmr > TMR_MAX) tmr = TMR_MAX;
      inwin = (tbat > tempmin) && (tbat < tempmax);
      rthr = int'(vpreset) - RECHG;
      if (rthr < 0) rthr = 0;
      deb = (m_st == S_CV && ibat < iend) ? m_deb + 1 : 0;
      if (!en || !vtok) begin
        st = S_IDLE; act = 0; flt = 0; res = S_TC;
      end else begin
        case (m_st)
          S_IDLE: st = S_WAIT;
          S_WAIT: if (vbat > vmax) st = S_DONE; else if (inwin) st = res;
          S_TC, S_CC, S_CV: begin
            act = act + 1;
            if (vbat > vmax) begin st = S_FAULT; flt = 2; end
            else if (tmr == int'(tmax)) begin
              if (m_st == S_CV) st = S_DONE; else begin st = S_FAULT; flt = 1; end
            end
            else if (!inwin) begin res = m_st; st = S_WAIT; end
            else if (m_st == S_TC && vbat > vcutoff) st = S_CC;
            else if (m_st == S_CC && vbat > vpreset) st = S_CV;
            else if (m_st == S_CV && deb == DEB) st = S_DONE;
          end
          S_DONE: begin
            act = 0;
            if (vbat < vcutoff) st = S_TC;
            else if (int'(vbat) < rthr) st = S_CC;
          end
          default: ;
        endcase
      end
      m_st <= st; m_active <= act; m_deb <= deb; m_fault <= flt; m_resume <= res;
    end
  end

  always @(posedge clk) begin : compare
    int emode;
    #2;
    emode = (m_st == S_TC) ? 4 : (m_st == S_CC) ? 2 : (m_st == S_CV) ? 1 : 0;
    check("m_state", int'(state), m_st);
    check("m_fault", int'(fault), m_fault);
    check("m_mode_tc_cc_cv", int'({tc, cc, cv}), emode);
    check("m_done", int'(done), int'(m_st == S_DONE));
    check("m_imonen", int'(imonen), int'(m_st == S_CC || m_st == S_CV || m_st == S_DONE));
    check("m_vt_monen", int'({vmonen, tmonen}), (m_st != S_IDLE) ? 3 : 0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps until state==target, counting cycles spent in TC/CC; expiry is a failure
  task automatic run_until(input int target, input int budget, inout int cnt);
    int k;
    for (k = 0; k < budget; k++) begin
      step(1);
      if (state == 3'(S_TC) || state == 3'(S_CC)) cnt++;
      if (int'(state) == target) break;
    end
    check("run_until_budget", int'(k < budget), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    step(2);
    check("rst_state", int'(state), S_IDLE);
    check("rst_outs", int'({cc, tc, cv, imonen, vmonen, tmonen, fault, done}), 0);
    rstz = 1'b1;
    step(1);
    en = 1'b1; vtok = 1'b1;
    step(2);
    check("full_tc", int'(state), S_TC);
    check("full_tc_mode", int'({tc, cc, cv}), 3'b100);
    vbat = 8'd150; step(1);
    check("full_cc", int'(state), S_CC);
    vbat = 8'd190; step(1);
    check("full_cv", int'(state), S_CV);
    ibat = 8'd5; step(3);
    check("deb_3_hold", int'(state), S_CV);
    step(1);
    check("deb_4_done", int'(state), S_DONE);
    check("done_flag", int'(done), 1);
    check("done_mon", int'({imonen, vmonen, tmonen}), 3'b111);
    vbat = 8'd179; ibat = 8'd100; step(1);
    check("rechg_cc", int'(state), S_CC);
    vbat = 8'd190; step(1);
    check("rechg_cv", int'(state), S_CV);
    ibat = 8'd5; step(2); ibat = 8'd100; step(1); ibat = 8'd5; step(3);
    check("glitch_hold", int'(state), S_CV);
    step(1);
    check("glitch_done", int'(state), S_DONE);
    vbat = 8'd140; ibat = 8'd100; step(1);
    check("rechg_tc", int'(state), S_TC);

    en = 1'b0; step(1);
    tmax = 8'd3; vbat = 8'd100; en = 1'b1; cnt = 0;
    run_until(S_FAULT, 100, cnt);
    check("to_tc_cycles", cnt, 13);
    check("to_fault", int'(fault), 1);
    check("to_mode_off", int'({tc, cc, cv}), 0);
    en = 1'b0; step(1);
    check("to_idle", int'(state), S_IDLE);
    check("to_fault_clr", int'(fault), 0);

    tmax = 8'd5; vbat = 8'd150; en = 1'b1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (state == 3'(S_TC) || state == 3'(S_CC)) cnt++;
    end
    check("pause_pre_cc", int'(state), S_CC);
    tbat = 8'd120; step(50);
    check("pause_wait", int'(state), S_WAIT);
    tbat = 8'd50; step(1);
    check("pause_resume_cc", int'(state), S_CC);
    cnt++;
    run_until(S_FAULT, 100, cnt);
    check("pause_active_cycles", cnt, 21);
    check("pause_fault", int'(fault), 1);
    en = 1'b0; step(1);

    tmax = 8'd200; vbat = 8'd190; en = 1'b1; step(4);
    check("ov_cv", int'(state), S_CV);
    vbat = 8'd220; step(1);
    check("ov_state", int'(state), S_FAULT);
    check("ov_fault", int'(fault), 2);
    check("ov_mode_off", int'({tc, cc, cv}), 0);
    en = 1'b0; vbat = 8'd190; step(1);

    en = 1'b1; step(4);
    check("ar_cv", int'(state), S_CV);
    ibat = 8'd5; step(2);
    #3 rstz = 1'b0;
    #1;
    check("ar_state", int'(state), S_IDLE);
    check("ar_outs", int'({cc, tc, cv, imonen, vmonen, tmonen, fault, done}), 0);
    step(2);
    rstz = 1'b1; ibat = 8'd100;
    step(3);
    check("ar_restart_tc", int'(state), S_CC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
